check_node_min_tracker: RTL and testbench
=========================================

Name: check_node_min_tracker

Overview:
Streaming check-node core for the min-sum LDPC decoder. Accepts one IEEE-754 single-precision variable-to-check message per handshake and runs a full row of DEG messages through a magnitude compare. Tracks the smallest magnitude (min1), its position, the second-smallest magnitude (min2) and the XOR of all sign bits. Sits directly downstream of the floating-point magnitude comparator and consumes its less-than decision. Feeds the check-to-variable message generator.

Parameters:
DEG, 6, messages per check row (>=2)
IDX_W, 3, width of index/counter fields; 2**IDX_W >= DEG

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_msg valid
in_ready  output  1  block can accept a message
in_msg  input  32  variable-to-check message, IEEE-754 single
out_valid  output  1  row result valid
out_ready  input  1  downstream accepts result
min1  output  32  smallest magnitude, sign bit forced 0
min2  output  32  second-smallest magnitude, sign bit forced 0
min1_idx  output  IDX_W  position (0..DEG-1) of min1 within the row
sign_prod  output  1  XOR of sign bits of all DEG messages
err  output  1  sticky special-value flag (only with NAN_FLAG_EN; tied 0 otherwise)

Behaviour:
- Reset, asynchronous, rst_n low:
  - state=ACCUM, count=0, min1=0, min2=0, min1_idx=0, sign_prod=0, out_valid=0, err=0.
  - in_ready=1 once reset is released.
- Magnitude compare, lt(a,b):
  - a[30:23] < b[30:23], or (a[30:23]==b[30:23] and a[22:0] < b[22:0]).
  - Sign bits are ignored.
  - Equal magnitudes give lt=0.
- in_ready = (state==ACCUM). A message is accepted on a rising edge with in_valid && in_ready.
- States:
  - ACCUM: accept messages. On each accept, with m = {1'b0, in_msg[30:0]}:
    - count==0: min1=m, min1_idx=0, min2=32'h7F800000, sign_prod=in_msg[31].
    - else if lt(m,min1): min2=min1, min1=m, min1_idx=count.
    - else if lt(m,min2): min2=m.
    - else: no magnitude change.
    - sign_prod ^= in_msg[31] on every accept after the first.
    - count increments. When the accepted message has count==DEG-1: count=0, state=HOLD, out_valid=1 on the same edge.
  - HOLD:
    - out_valid=1; min1, min2, min1_idx and sign_prod are stable.
    - in_ready=0.
    - On an edge with out_ready=1: out_valid=0, state=ACCUM. Output registers keep their values until the next row's first accept overwrites them.
- Latency:
  - out_valid rises on the same edge that accepts the DEG-th message.
  - Minimum row period is DEG+1 cycles; the HOLD cycle is always spent.
- in_valid gaps in ACCUM: state and count hold, and the partial result is retained indefinitely.
- in_valid during HOLD is ignored (not accepted). Upstream must hold the message.
- Ties:
  - A message equal to min1 does not replace min1, so the earliest index wins.
  - It becomes min2 if lt(m,min2).
- Reset mid-row or in HOLD: partial row is discarded and all registers return to reset values. The next accepted message is treated as index 0.
- Inputs with exponent 8'hFF (Inf/NaN) are compared as raw bits; no special handling in the datapath.

Optional Feature:
NAN_FLAG_EN
- Defined:
  - err is set on any accepted in_msg with in_msg[30:23]==8'hFF.
  - err stays set until rst_n is asserted; it is not cleared by row completion.
  - The datapath is unchanged.
- Undefined: err is constant 0 and no detection logic is built.

Test Plan:
- Nominal row, DEG=6, in_valid held high. Stimulus: 3F800000, BF000000, 40000000, BE800000, 3F400000, 40400000. Required: out_valid rises on the 6th accept edge, min1=3E800000, min1_idx=3, min2=3F000000, sign_prod=0.
- Ties. Six messages of 3F800000 with one negative (BF800000 at index 2). Required: min1=3F800000, min1_idx=0, min2=3F800000, sign_prod=1.
- Backpressure. After the nominal row, hold out_ready=0 for 5 cycles. Required:
  - out_valid=1, in_ready=0 and all outputs constant throughout.
  - in_valid=1 during HOLD is not accepted.
  - out_ready=1 gives out_valid=0 next cycle and in_ready=1.
- Input gaps. Nominal row with in_valid low for 3 cycles between each message. Required: the same result as the nominal row; count does not advance during gaps.
- Reset mid-row. Accept 3 messages, pulse rst_n low between clock edges. Required:
  - Outputs are immediately 0.
  - A following row of 40A00000, 40800000, 40400000, 40000000, 3F800000, 3F000000 yields min1=3F000000, min1_idx=5, min2=3F800000, sign_prod=0.
- NAN_FLAG_EN. Row containing 7FC00000 at index 1. Required: err=1 after that accept and still 1 after the next clean row; err=0 after rst_n. With the macro undefined, err stays 0.

Source files
------------

// File: rtl/check_node_min_tracker.sv
// Min-sum LDPC check-node tracker: streams DEG messages per row and reports min1, min2, min1 position and sign product.
// Optional macro NAN_FLAG_EN builds a sticky flag for accepted Inf/NaN inputs; without it, err is tied 0.
//
// state | meaning
// ACCUM | accepting row messages, in_ready=1
// HOLD  | row result valid, waiting for out_ready
module check_node_min_tracker #(
    parameter int DEG   = 6,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_msg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      min1,
    output logic [31:0]      min2,
    output logic [IDX_W-1:0] min1_idx,
    output logic             sign_prod,
    output logic             err
);

    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    state_t           state_q;
    logic [IDX_W-1:0] count_q;
    logic [IDX_W-1:0] count_d;
    logic [31:0]      min1_q;
    logic [31:0]      min2_q;
    logic [IDX_W-1:0] idx_q;
    logic             sign_q;
    logic             out_valid_q;

    logic [31:0]      mag;
    logic             accept;
    logic             last;
    logic             lt_min1;
    logic             lt_min2;

    // Sign is ignored; exponent/mantissa order as raw bits, equal gives 0.
    function automatic logic lt(input logic [31:0] a, input logic [31:0] b);
        return (a[30:23] < b[30:23]) || ((a[30:23] == b[30:23]) && (a[22:0] < b[22:0]));
    endfunction

    always_comb begin
        mag     = {1'b0, in_msg[30:0]};
        accept  = in_valid && (state_q == ACCUM);
        last    = (count_q == IDX_W'(DEG - 1));
        count_d = count_q + 1'b1;
        lt_min1 = lt(mag, min1_q);
        lt_min2 = lt(mag, min2_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            count_q     <= '0;
            min1_q      <= '0;
            min2_q      <= '0;
            idx_q       <= '0;
            sign_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        if (count_q == '0) begin
                            min1_q <= mag;
                            idx_q  <= '0;
                            min2_q <= POS_INF;
                            sign_q <= in_msg[31];
                        end else begin
                            // Ties never displace min1, so the earliest index wins.
                            if (lt_min1) begin
                                min2_q <= min1_q;
                                min1_q <= mag;
                                idx_q  <= count_q;
                            end else if (lt_min2) begin
                                min2_q <= mag;
                            end
                            sign_q <= sign_q ^ in_msg[31];
                        end
                        if (last) begin
                            count_q     <= '0;
                            state_q     <= HOLD;
                            out_valid_q <= 1'b1;
                        end else begin
                            count_q <= count_d;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ACCUM;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = out_valid_q;
    assign min1      = min1_q;
    assign min2      = min2_q;
    assign min1_idx  = idx_q;
    assign sign_prod = sign_q;

`ifdef NAN_FLAG_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept && (in_msg[30:23] == 8'hFF)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_check_node_min_tracker.sv
// Directed bench for check_node_min_tracker: nominal, ties, backpressure, gaps, mid-row reset, Inf/NaN flag.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_check_node_min_tracker;

    localparam int IDX_W = 3;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_msg;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      min1;
    logic [31:0]      min2;
    logic [IDX_W-1:0] min1_idx;
    logic             sign_prod;
    logic             err;

    int n_tests = 0;
    int n_fail  = 0;

    check_node_min_tracker #(.DEG(6), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_msg    (in_msg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .min1      (min1),
        .min2      (min2),
        .min1_idx  (min1_idx),
        .sign_prod (sign_prod),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the accepting rising edge.
    task automatic send(input logic [31:0] m);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_msg   = m;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                                input logic [31:0] eidx, input logic [31:0] esign);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_min1"},  min1, e1);
        check({tag, "_min2"},  min2, e2);
        check({tag, "_idx"},   32'(min1_idx), eidx);
        check({tag, "_sign"},  32'(sign_prod), esign);
    endtask

    logic [31:0] nominal [6] = '{32'h3F800000, 32'hBF000000, 32'h40000000,
                                 32'hBE800000, 32'h3F400000, 32'h40400000};
    logic [31:0] ties    [6] = '{32'h3F800000, 32'h3F800000, 32'hBF800000,
                                 32'h3F800000, 32'h3F800000, 32'h3F800000};
    logic [31:0] descend [6] = '{32'h40A00000, 32'h40800000, 32'h40400000,
                                 32'h40000000, 32'h3F800000, 32'h3F000000};
    logic [31:0] nanrow  [6] = '{32'h3F800000, 32'h7FC00000, 32'h40000000,
                                 32'h40400000, 32'h40800000, 32'h40A00000};

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_msg    = '0;
        out_ready = 1'b1;
        #12;
        check("rst_min1", min1, 32'h0);
        check("rst_min2", min2, 32'h0);
        check("rst_idx", 32'(min1_idx), 32'h0);
        check("rst_sign", 32'(sign_prod), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Nominal row with backpressure afterwards.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send(nominal[i]);
            if (i == 4) check("nom_early_valid", 32'(out_valid), 32'h0);
        end
        check_result("nom", 32'h3E800000, 32'h3F000000, 32'd3, 32'd0);
        in_valid = 1'b1;
        in_msg   = 32'h00000001;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_min1", min1, 32'h3E800000);
            check("bp_min2", min2, 32'h3F000000);
            check("bp_idx", 32'(min1_idx), 32'd3);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        check("bp_retained_min1", min1, 32'h3E800000);

        // Ties: equal magnitudes keep the first index and populate min2.
        for (int i = 0; i < 6; i++) send(ties[i]);
        check_result("tie", 32'h3F800000, 32'h3F800000, 32'd0, 32'd1);
        @(negedge clk);

        // Nominal row with 3-cycle input gaps.
        for (int i = 0; i < 6; i++) begin
            send(nominal[i]);
            if (i < 5) begin
                repeat (3) @(negedge clk);
                check("gap_no_valid", 32'(out_valid), 32'h0);
            end
        end
        check_result("gap", 32'h3E800000, 32'h3F000000, 32'd3, 32'd0);
        @(negedge clk);

        // Reset after three accepts of a row.
        send(32'h3E000000);
        send(32'hBE000000);
        send(32'h3D000000);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_min1", min1, 32'h0);
        check("mid_rst_min2", min2, 32'h0);
        check("mid_rst_sign", 32'(sign_prod), 32'h0);
        check("mid_rst_valid", 32'(out_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            send(descend[i]);
            if (i == 4) check("post_rst_early_valid", 32'(out_valid), 32'h0);
        end
        check_result("post_rst", 32'h3F000000, 32'h3F800000, 32'd5, 32'd0);
        @(negedge clk);

        // Inf/NaN input: sticky flag only when the feature is built in.
        send(nanrow[0]);
        send(nanrow[1]);
`ifdef NAN_FLAG_EN
        check("nan_err_set", 32'(err), 32'd1);
`else
        check("nan_err_tied", 32'(err), 32'd0);
`endif
        for (int i = 2; i < 6; i++) send(nanrow[i]);
        check_result("nan", 32'h3F800000, 32'h40000000, 32'd0, 32'd0);
        @(negedge clk);
        for (int i = 0; i < 6; i++) send(nominal[i]);
        check_result("nan_clean", 32'h3E800000, 32'h3F000000, 32'd3, 32'd0);
`ifdef NAN_FLAG_EN
        check("nan_err_sticky", 32'(err), 32'd1);
`else
        check("nan_err_still0", 32'(err), 32'd0);
`endif
        rst_n = 1'b0;
        @(negedge clk);
        check("nan_err_cleared", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
